// File: rtl/automata_trace_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : automata_trace_decoder
//  Description : Receive-side decoder for the transition-code stream of the
//                6-state lab automaton. Tracks the automaton state from the
//                codes, reports each decoded step, flags illegal codes and
//                re-synchronises once an error has been cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module automata_trace_decoder #(
    parameter int CNT_W        = 16,
    parameter int START_LOCKED = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       code,
    input  logic             clr_err,
    output logic [2:0]       cur_state,
    output logic             locked,
    output logic             step_valid,
    output logic [2:0]       step_from,
    output logic [2:0]       step_to,
    output logic             err,
    output logic [7:0]       err_code,
    output logic [2:0]       err_state,
    output logic [CNT_W-1:0] trans_cnt
);

    localparam logic [1:0] c_ST_SYNC  = 2'd0;
    localparam logic [1:0] c_ST_TRACK = 2'd1;
    localparam logic [1:0] c_ST_ERROR = 2'd2;

    localparam logic [2:0] c_UNKNOWN  = 3'd7;
    localparam logic [7:0] c_NOP      = 8'h00;

    localparam logic             c_START_LOCKED = (START_LOCKED != 0);
    localparam logic [1:0]       c_RST_STATE    = c_START_LOCKED ? c_ST_TRACK : c_ST_SYNC;
    localparam logic [2:0]       c_RST_CUR      = c_START_LOCKED ? 3'd0 : c_UNKNOWN;
    localparam logic [CNT_W-1:0] c_CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    // Legal transition lookup: returns {hit, destination} for a code seen in state s.
    function automatic logic [3:0] track_next(input logic [2:0] s, input logic [7:0] c);
        logic [3:0] r;
        r = 4'b0000;
        case (s)
            3'd0: if (c == 8'h91) r = {1'b1, 3'd5};
            3'd1: begin
                if (c == 8'h7F) r = {1'b1, 3'd4};
                if (c == 8'h91) r = {1'b1, 3'd5};
            end
            3'd2: if (c == 8'h71) r = {1'b1, 3'd5};
            3'd3: begin
                if (c == 8'h39) r = {1'b1, 3'd0};
                if (c == 8'hB6) r = {1'b1, 3'd1};
                if (c == 8'h96) r = {1'b1, 3'd2};
            end
            3'd4: begin
                if (c == 8'hA8) r = {1'b1, 3'd0};
                if (c == 8'h7F) r = {1'b1, 3'd3};
            end
            3'd5: begin
                if (c == 8'h7F) r = {1'b1, 3'd1};
                if (c == 8'hB7) r = {1'b1, 3'd4};
            end
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    // Codes whose destination is unique regardless of source state: {hit, destination}.
    function automatic logic [3:0] sync_next(input logic [7:0] c);
        logic [3:0] r;
        case (c)
            8'h91:   r = {1'b1, 3'd5};
            8'h71:   r = {1'b1, 3'd5};
            8'h39:   r = {1'b1, 3'd0};
            8'hB6:   r = {1'b1, 3'd1};
            8'h96:   r = {1'b1, 3'd2};
            8'hA8:   r = {1'b1, 3'd0};
            8'hB7:   r = {1'b1, 3'd4};
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [3:0]       w_track;
    logic [3:0]       w_sync;
    logic             w_is_nop;

    logic [2:0]       w_cur_state;
    logic             w_locked;
    logic             w_step_valid;
    logic [2:0]       w_step_from;
    logic [2:0]       w_step_to;
    logic             w_err;
    logic [7:0]       w_err_code;
    logic [2:0]       w_err_state;
    logic [CNT_W-1:0] w_trans_cnt;

    assign w_track  = track_next(cur_state, code);
    assign w_sync   = sync_next(code);
    assign w_is_nop = (code == c_NOP);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_RST_STATE;
        else     r_state <= w_next_state;
    end

    // Next-state decision from the sampled code and error clear.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_TRACK: if (in_valid && !w_is_nop && !w_track[3]) w_next_state = c_ST_ERROR;
            c_ST_ERROR: if (clr_err)                            w_next_state = c_ST_SYNC;
            c_ST_SYNC:  if (in_valid && w_sync[3])              w_next_state = c_ST_TRACK;
            default:                                            w_next_state = c_ST_SYNC;
        endcase
    end

    // Next values of the registered outputs; everything holds unless an event updates it.
    always_comb begin
        w_cur_state  = cur_state;
        w_locked     = locked;
        w_step_valid = 1'b0;
        w_step_from  = step_from;
        w_step_to    = step_to;
        w_err        = err;
        w_err_code   = err_code;
        w_err_state  = err_state;
        w_trans_cnt  = trans_cnt;
        case (r_state)
            c_ST_TRACK: begin
                if (in_valid && !w_is_nop) begin
                    if (w_track[3]) begin
                        w_cur_state  = w_track[2:0];
                        w_step_valid = 1'b1;
                        w_step_from  = cur_state;
                        w_step_to    = w_track[2:0];
                        if (!(&trans_cnt)) w_trans_cnt = trans_cnt + c_CNT_ONE;
                    end else begin
                        w_err       = 1'b1;
                        w_err_code  = code;
                        w_err_state = cur_state;
                        w_locked    = 1'b0;
                        w_cur_state = c_UNKNOWN;
                    end
                end
            end
            c_ST_ERROR: begin
                // A simultaneous code is dropped; only the clear is acted on.
                if (clr_err) w_err = 1'b0;
            end
            c_ST_SYNC: begin
                if (in_valid && w_sync[3]) begin
                    w_cur_state = w_sync[2:0];
                    w_locked    = 1'b1;
                end
            end
            default: begin
                w_cur_state = c_UNKNOWN;
                w_locked    = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= c_RST_CUR;
            locked     <= c_START_LOCKED;
            step_valid <= 1'b0;
            step_from  <= 3'd0;
            step_to    <= 3'd0;
            err        <= 1'b0;
            err_code   <= 8'h00;
            err_state  <= 3'd0;
            trans_cnt  <= '0;
        end else begin
            cur_state  <= w_cur_state;
            locked     <= w_locked;
            step_valid <= w_step_valid;
            step_from  <= w_step_from;
            step_to    <= w_step_to;
            err        <= w_err;
            err_code   <= w_err_code;
            err_state  <= w_err_state;
            trans_cnt  <= w_trans_cnt;
        end
    end

endmodule
`default_nettype wire
